// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer in front of a single-port
// data memory (combinational read, write on rising CLK). Requester 0 is the
// CPU load/store path, requester 1 is the program/data loader. Sub-word
// stores become a read-modify-write sequence because the memory only writes
// whole words.
//
// Handshake: a request transfers in the cycle where REQx_VALID and REQx_READY
// are both 1. READY is combinational, asserted only in IDLE and only for the
// granted requester. A requester holds its fields stable while VALID=1 and
// READY=0. Every accepted request yields exactly one RSPx_VALID pulse
// (1 cycle later, or 2 cycles later for a partial store).
module dmem_arbiter #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 32
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               REQ0_VALID,
    output logic               REQ0_READY,
    input  logic               REQ0_WE,
    input  logic [A_WIDTH-1:0] REQ0_A,
    input  logic [D_WIDTH-1:0] REQ0_WD,
    input  logic [3:0]         REQ0_BE,
    output logic               RSP0_VALID,
    output logic [D_WIDTH-1:0] RSP0_RD,
    input  logic               REQ1_VALID,
    output logic               REQ1_READY,
    input  logic               REQ1_WE,
    input  logic [A_WIDTH-1:0] REQ1_A,
    input  logic [D_WIDTH-1:0] REQ1_WD,
    input  logic [3:0]         REQ1_BE,
    output logic               RSP1_VALID,
    output logic [D_WIDTH-1:0] RSP1_RD,
    output logic [A_WIDTH-1:0] MEM_A,
    output logic [D_WIDTH-1:0] MEM_WD,
    output logic               MEM_WE,
    input  logic [D_WIDTH-1:0] MEM_RD,
    output logic               DBG_RMW      // 1 while the FSM is in RMW_WR
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               last_q, last_d;          // requester granted last
    logic [A_WIDTH-1:0] rmw_a_q, rmw_a_d;
    logic [D_WIDTH-1:0] rmw_wd_q, rmw_wd_d;
    logic               rmw_port_q, rmw_port_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [D_WIDTH-1:0] rsp0_rd_q, rsp0_rd_d;
    logic [D_WIDTH-1:0] rsp1_rd_q, rsp1_rd_d;

    logic               req_any;
    logic               gnt_id;
    logic               sel_we;
    logic [A_WIDTH-1:0] sel_a;
    logic [D_WIDTH-1:0] sel_wd;
    logic [3:0]         sel_be;
    logic [D_WIDTH-1:0] merged;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        req_any = REQ0_VALID | REQ1_VALID;
        gnt_id  = (REQ0_VALID && REQ1_VALID) ? ~last_q : REQ1_VALID;
        sel_we  = gnt_id ? REQ1_WE : REQ0_WE;
        sel_a   = gnt_id ? REQ1_A  : REQ0_A;
        sel_wd  = gnt_id ? REQ1_WD : REQ0_WD;
        sel_be  = gnt_id ? REQ1_BE : REQ0_BE;
    end

    // Byte merge of store data over the current memory word for partial stores.
    always_comb begin
        merged = MEM_RD;
        for (int i = 0; i < 4; i++) begin
            if (sel_be[i]) merged[8*i +: 8] = sel_wd[8*i +: 8];
        end
    end

    // Next-state, memory port and response scheduling.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        rmw_a_d      = rmw_a_q;
        rmw_wd_d     = rmw_wd_q;
        rmw_port_d   = rmw_port_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_rd_d    = rsp0_rd_q;
        rsp1_rd_d    = rsp1_rd_q;
        REQ0_READY   = 1'b0;
        REQ1_READY   = 1'b0;
        MEM_A        = '0;
        MEM_WD       = '0;
        MEM_WE       = 1'b0;
        case (state_q)
            IDLE: begin
                // Gate with RST_N so nothing is granted while reset is held.
                if (req_any && RST_N) begin
                    REQ0_READY = ~gnt_id;
                    REQ1_READY = gnt_id;
                    last_d     = gnt_id;
                    MEM_A      = sel_a;
                    if (!sel_we) begin
                        if (gnt_id) begin
                            rsp1_valid_d = 1'b1;
                            rsp1_rd_d    = MEM_RD;
                        end else begin
                            rsp0_valid_d = 1'b1;
                            rsp0_rd_d    = MEM_RD;
                        end
                    end else if (sel_be == 4'b1111 || sel_be == 4'b0000) begin
                        MEM_WE       = (sel_be == 4'b1111);
                        MEM_WD       = (sel_be == 4'b1111) ? sel_wd : '0;
                        rsp0_valid_d = ~gnt_id;
                        rsp1_valid_d = gnt_id;
                    end else begin
                        rmw_a_d    = sel_a;
                        rmw_wd_d   = merged;
                        rmw_port_d = gnt_id;
                        state_d    = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                MEM_A        = rmw_a_q;
                MEM_WD       = rmw_wd_q;
                MEM_WE       = 1'b1;
                rsp0_valid_d = ~rmw_port_q;
                rsp1_valid_d = rmw_port_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset abandons any pending RMW.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            rmw_a_q      <= '0;
            rmw_wd_q     <= '0;
            rmw_port_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rd_q    <= '0;
            rsp1_rd_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            rmw_a_q      <= rmw_a_d;
            rmw_wd_q     <= rmw_wd_d;
            rmw_port_q   <= rmw_port_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rd_q    <= rsp0_rd_d;
            rsp1_rd_q    <= rsp1_rd_d;
        end
    end

    assign RSP0_VALID = rsp0_valid_q;
    assign RSP1_VALID = rsp1_valid_q;
    assign RSP0_RD    = rsp0_rd_q;
    assign RSP1_RD    = rsp1_rd_q;
    assign DBG_RMW    = (state_q == RMW_WR);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory, table of single-requester
// vectors, random single-requester traffic, and hand-written sequences for
// the RMW, reset-during-RMW and contention corner cases. Responses are
// checked by a scoreboard queue of {due cycle, port, data}.
module tb_dmem_arbiter;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          CLK;
    logic          RST_N;
    logic          REQ0_VALID, REQ0_READY, REQ0_WE;
    logic [AW-1:0] REQ0_A;
    logic [DW-1:0] REQ0_WD;
    logic [3:0]    REQ0_BE;
    logic          RSP0_VALID;
    logic [DW-1:0] RSP0_RD;
    logic          REQ1_VALID, REQ1_READY, REQ1_WE;
    logic [AW-1:0] REQ1_A;
    logic [DW-1:0] REQ1_WD;
    logic [3:0]    REQ1_BE;
    logic          RSP1_VALID;
    logic [DW-1:0] RSP1_RD;
    logic [AW-1:0] MEM_A;
    logic [DW-1:0] MEM_WD;
    logic          MEM_WE;
    logic [DW-1:0] MEM_RD;
    logic          DBG_RMW;

    dmem_arbiter #(.A_WIDTH(AW), .D_WIDTH(DW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
        .REQ0_A(REQ0_A), .REQ0_WD(REQ0_WD), .REQ0_BE(REQ0_BE),
        .RSP0_VALID(RSP0_VALID), .RSP0_RD(RSP0_RD),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
        .REQ1_A(REQ1_A), .REQ1_WD(REQ1_WD), .REQ1_BE(REQ1_BE),
        .RSP1_VALID(RSP1_VALID), .RSP1_RD(RSP1_RD),
        .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE), .MEM_RD(MEM_RD),
        .DBG_RMW(DBG_RMW)
    );

    // ---------------- clock / reset / memory ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    logic [DW-1:0] mem     [0:63];
    logic [DW-1:0] ref_mem [0:63];
    assign MEM_RD = mem[MEM_A[5:0]];
    always @(posedge CLK) if (MEM_WE) mem[MEM_A[5:0]] <= MEM_WD;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [48:0]   exp_q[$];          // {due[15:0], port, data[31:0]}
    logic [DW-1:0] last_ld [0:1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_exp(input int p, input int lat, input logic [DW-1:0] d);
        logic [15:0] due;
        due = 16'(cyc + lat);
        exp_q.push_back({due, p[0], d});
    endtask

    task automatic pop_chk(input int p, input logic [DW-1:0] rd);
        logic [48:0] e;
        if (exp_q.size() == 0) begin
            chk($sformatf("rsp%0d_unexpected", p), 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_port", 64'(p), 64'(e[32]));
            chk("rsp_cycle", 64'(cyc[15:0]), 64'(e[48:33]));
            chk("rsp_rd", 64'(rd), 64'(e[31:0]));
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (RSP0_VALID && RSP1_VALID) chk("rsp_both_ports", 1, 0);
        if (RSP0_VALID) pop_chk(0, RSP0_RD);
        if (RSP1_VALID) pop_chk(1, RSP1_RD);
    end

    // ---------------- driver ----------------
    task automatic drive(input int p, input logic v, input logic we, input logic [5:0] a,
                         input logic [DW-1:0] wd, input logic [3:0] be);
        if (p == 0) begin
            REQ0_VALID = v; REQ0_WE = we; REQ0_A = AW'(a); REQ0_WD = wd; REQ0_BE = be;
        end else begin
            REQ1_VALID = v; REQ1_WE = we; REQ1_A = AW'(a); REQ1_WD = wd; REQ1_BE = be;
        end
    endtask

    // Single-requester transaction with a bounded wait for acceptance.
    task automatic issue(input int p, input logic we, input logic [5:0] a, input logic [DW-1:0] wd,
                         input logic [3:0] be, input logic [DW-1:0] exp_ld, input int lat);
        bit got;
        got = 0;
        @(posedge CLK); #1;
        drive(p, 1'b1, we, a, wd, be);
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge CLK);
            if ((p == 0) ? REQ0_READY : REQ1_READY) begin
                got = 1;
                chk("acc_mem_a", 64'(MEM_A), 64'(a));
                chk("acc_mem_we", 64'(MEM_WE), 64'(we && be == 4'hF));
                if (we && be == 4'hF) chk("acc_mem_wd", 64'(MEM_WD), 64'(wd));
                if (!we) begin
                    last_ld[p] = exp_ld;
                    push_exp(p, lat, exp_ld);
                end else begin
                    push_exp(p, lat, last_ld[p]);
                    for (int i = 0; i < 4; i++)
                        if (be[i]) ref_mem[a][8*i +: 8] = wd[8*i +: 8];
                end
            end else begin
                @(posedge CLK); #1;
            end
        end
        if (!got) chk($sformatf("accept_timeout_p%0d", p), 0, 1);
        @(posedge CLK); #1;
        drive(p, 1'b0, 1'b0, 6'd0, '0, 4'h0);
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [5:0]  a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int p, lat;
        logic we;
        logic [5:0] a;
        logic [3:0] be;
        logic [31:0] wd;

        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[5] = 32'hDEADBEEF; mem[3] = 32'hAABBCCDD; mem[2] = 32'h01020304;
        mem[12] = 32'h11223344; mem[20] = 32'hCAFEF00D;
        for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
        last_ld[0] = '0; last_ld[1] = '0;

        tbl[0] = '{0, 1'b0, 6'd5,  32'h0,        4'h0, 32'hDEADBEEF, 1};
        tbl[1] = '{1, 1'b1, 6'd7,  32'h12345678, 4'hF, 32'h0,        1};
        tbl[2] = '{1, 1'b0, 6'd7,  32'h0,        4'h0, 32'h12345678, 1};
        tbl[3] = '{1, 1'b1, 6'd9,  32'hFFFFFFFF, 4'h0, 32'h0,        1};
        tbl[4] = '{1, 1'b0, 6'd9,  32'h0,        4'h0, 32'h10000009, 1};
        tbl[5] = '{0, 1'b1, 6'd2,  32'hAA000000, 4'h8, 32'h0,        2};
        tbl[6] = '{0, 1'b0, 6'd2,  32'h0,        4'h0, 32'hAA020304, 1};
        tbl[7] = '{1, 1'b1, 6'd12, 32'h55667788, 4'h5, 32'h0,        2};
        tbl[8] = '{1, 1'b0, 6'd12, 32'h0,        4'h0, 32'h11663388, 1};

        RST_N = 1'b0;
        drive(0, 1'b0, 1'b0, 6'd0, '0, 4'h0);
        drive(1, 1'b0, 1'b0, 6'd0, '0, 4'h0);
        #3;
        chk("rst_ready0", 64'(REQ0_READY), 0);
        chk("rst_ready1", 64'(REQ1_READY), 0);
        chk("rst_rsp0_valid", 64'(RSP0_VALID), 0);
        chk("rst_rsp1_valid", 64'(RSP1_VALID), 0);
        chk("rst_rsp0_rd", 64'(RSP0_RD), 0);
        chk("rst_rsp1_rd", 64'(RSP1_RD), 0);
        chk("rst_mem_we", 64'(MEM_WE), 0);
        chk("rst_mem_a", 64'(MEM_A), 0);
        chk("rst_mem_wd", 64'(MEM_WD), 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b1;

        // Table-driven single-requester vectors.
        for (int i = 0; i < 9; i++)
            issue(tbl[i].port, tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].be, tbl[i].exp_rd, tbl[i].lat);

        // Partial store with a port-1 load waiting through RMW_WR.
        @(posedge CLK); #1;
        drive(0, 1'b1, 1'b1, 6'd3, 32'h00001122, 4'b0011);
        @(negedge CLK);
        chk("rmw_acc_ready0", 64'(REQ0_READY), 1);
        chk("rmw_acc_mem_we", 64'(MEM_WE), 0);
        push_exp(0, 2, last_ld[0]);
        ref_mem[3] = 32'hAABB1122;
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b0, 6'd0, '0, 4'h0);
        drive(1, 1'b1, 1'b0, 6'd3, '0, 4'h0);
        @(negedge CLK);
        chk("rmw_state", 64'(DBG_RMW), 1);
        chk("rmw_mem_we", 64'(MEM_WE), 1);
        chk("rmw_mem_a", 64'(MEM_A), 3);
        chk("rmw_mem_wd", 64'(MEM_WD), 64'h AABB1122);
        chk("rmw_ready0", 64'(REQ0_READY), 0);
        chk("rmw_ready1", 64'(REQ1_READY), 0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("post_rmw_ready1", 64'(REQ1_READY), 1);
        last_ld[1] = 32'hAABB1122;
        push_exp(1, 1, 32'hAABB1122);
        @(posedge CLK); #1;
        drive(1, 1'b0, 1'b0, 6'd0, '0, 4'h0);

        // Random single-requester traffic over words 0..15.
        for (int i = 0; i < 24; i++) begin
            p  = int'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            a  = 6'($urandom_range(0, 15));
            be = 4'($urandom_range(0, 15));
            wd = $urandom;
            lat = (we && be != 4'h0 && be != 4'hF) ? 2 : 1;
            issue(p, we, a, wd, be, ref_mem[a], lat);
        end
        repeat (3) @(posedge CLK);

        // Reset asserted during RMW_WR: write abandoned, no response.
        @(posedge CLK); #1;
        drive(0, 1'b1, 1'b1, 6'd20, 32'h000000EE, 4'b0001);
        @(negedge CLK);
        chk("rstmid_ready0", 64'(REQ0_READY), 1);
        @(posedge CLK); #1;
        drive(0, 1'b0, 1'b0, 6'd0, '0, 4'h0);
        @(negedge CLK);
        chk("rstmid_in_rmw", 64'(MEM_WE), 1);
        #1 RST_N = 1'b0;
        #1;
        chk("rstmid_mem_we", 64'(MEM_WE), 0);
        chk("rstmid_state", 64'(DBG_RMW), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("rstmid_rsp0", 64'(RSP0_VALID), 0);
        last_ld[0] = '0; last_ld[1] = '0;
        #2 RST_N = 1'b1;

        // Contention: both ports hold loads; grants alternate 0,1,0,1.
        @(posedge CLK); #1;
        drive(0, 1'b1, 1'b0, 6'd10, '0, 4'h0);
        drive(1, 1'b1, 1'b0, 6'd11, '0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk($sformatf("cont_ready0_%0d", i), 64'(REQ0_READY), 64'(i % 2 == 0));
            chk($sformatf("cont_ready1_%0d", i), 64'(REQ1_READY), 64'(i % 2 == 1));
            if (i % 2 == 0) begin
                last_ld[0] = ref_mem[10];
                push_exp(0, 1, ref_mem[10]);
            end else begin
                last_ld[1] = ref_mem[11];
                push_exp(1, 1, ref_mem[11]);
            end
            @(posedge CLK); #1;
        end
        drive(0, 1'b0, 1'b0, 6'd0, '0, 4'h0);
        drive(1, 1'b0, 1'b0, 6'd0, '0, 4'h0);

        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("exp_q_drained", 64'(exp_q.size()), 0);
        for (int i = 0; i < 32; i++) chk($sformatf("mem[%0d]", i), 64'(mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
